// File: rtl/mul_dispatch.sv
// rtl/mul_dispatch.sv - M-extension multiply issue/writeback controller
// One op in flight, scoreboard hazard checks, small result FIFO toward the register file.
module mul_dispatch #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [2:0]       dec_func3,
  input  logic [4:0]       dec_rs1_idx,
  input  logic [4:0]       dec_rs2_idx,
  input  logic [WIDTH-1:0] dec_rs1_val,
  input  logic [WIDTH-1:0] dec_rs2_val,
  input  logic [4:0]       dec_rd,
  output logic             mul_valid_in,
  output logic [2:0]       mul_func3,
  output logic [WIDTH-1:0] mul_rs1,
  output logic [WIDTH-1:0] mul_rs2,
  output logic [4:0]       mul_rd_tag,
  input  logic             mul_busy,
  input  logic             mul_valid_out,
  input  logic [WIDTH-1:0] mul_result,
  input  logic [4:0]       mul_rd_tag_out,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic [31:0]      sb_pending,
  output logic             err_tag,
  output logic             err_unexp
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_func3;
  logic [WIDTH-1:0] r_rs1;
  logic [WIDTH-1:0] r_rs2;
  logic [4:0]       r_rd;
  logic [31:0]      r_sb;
  logic             r_err_tag;
  logic             r_err_unexp;
  logic [4:0]       r_fifo_rd   [FIFO_DEPTH];
  logic [WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic        w_raw;
  logic        w_waw;
  logic        w_room;
  logic        w_can_accept;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_unexp;
  logic        w_tag_bad;
  logic [31:0] w_sb_set;
  logic [31:0] w_sb_clr;

  // Hazard checks ignore x0, which never has a pending write.
  assign w_raw = ((dec_rs1_idx != 5'd0) && r_sb[dec_rs1_idx]) ||
                 ((dec_rs2_idx != 5'd0) && r_sb[dec_rs2_idx]);
  assign w_waw = (dec_rd != 5'd0) && r_sb[dec_rd];
  assign w_room = (r_count < CW'(FIFO_DEPTH));
  assign w_can_accept = !rst && (r_state == S_IDLE) && !mul_busy && w_room && !w_raw && !w_waw;
  assign w_accept = dec_valid && w_can_accept;
  assign dec_ready = w_can_accept;

  assign wb_valid = (r_count != '0);
  assign wb_rd = r_fifo_rd[r_rptr];
  assign wb_data = r_fifo_data[r_rptr];
  assign w_pop = wb_valid && wb_ready;

  assign mul_func3 = r_func3;
  assign mul_rs1 = r_rs1;
  assign mul_rs2 = r_rs2;
  assign mul_rd_tag = r_rd;
  assign sb_pending = r_sb;
  assign err_tag = r_err_tag;
  assign err_unexp = r_err_unexp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    mul_valid_in = 1'b0;
    w_push       = 1'b0;
    w_unexp      = 1'b0;
    w_tag_bad    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_unexp = mul_valid_out;
        if (w_accept) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        mul_valid_in = 1'b1;
        w_unexp      = mul_valid_out;
        w_state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (mul_valid_out) begin
          w_push      = (r_rd != 5'd0);
          w_tag_bad   = (mul_rd_tag_out != r_rd);
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_sb_set = (w_accept && (dec_rd != 5'd0)) ? (32'd1 << dec_rd) : 32'd0;
  assign w_sb_clr = w_pop ? (32'd1 << wb_rd) : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_func3     <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_sb        <= '0;
      r_err_tag   <= 1'b0;
      r_err_unexp <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else begin
      if (w_accept) begin
        r_func3 <= dec_func3;
        r_rs1   <= dec_rs1_val;
        r_rs2   <= dec_rs2_val;
        r_rd    <= dec_rd;
      end
      r_sb <= ((r_sb & ~w_sb_clr) | w_sb_set) & ~32'd1;
      if (w_tag_bad) r_err_tag <= 1'b1;
      if (w_unexp)   r_err_unexp <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= r_rd;
      r_fifo_data[r_wptr] <= mul_result;
    end
  end

endmodule

// File: tb/tb_mul_dispatch.sv
// tb/tb_mul_dispatch.sv - directed table-driven bench for mul_dispatch
// The bench plays both decode and the multiplier.
module tb_mul_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic        dec_ready;
  logic [2:0]  dec_func3;
  logic [4:0]  dec_rs1_idx, dec_rs2_idx, dec_rd;
  logic [31:0] dec_rs1_val, dec_rs2_val;
  logic        mul_valid_in;
  logic [2:0]  mul_func3;
  logic [31:0] mul_rs1, mul_rs2;
  logic [4:0]  mul_rd_tag;
  logic        mul_busy, mul_valid_out;
  logic [31:0] mul_result;
  logic [4:0]  mul_rd_tag_out;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] sb_pending;
  logic        err_tag, err_unexp;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mul_dispatch #(.WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_func3(dec_func3),
    .dec_rs1_idx(dec_rs1_idx), .dec_rs2_idx(dec_rs2_idx),
    .dec_rs1_val(dec_rs1_val), .dec_rs2_val(dec_rs2_val), .dec_rd(dec_rd),
    .mul_valid_in(mul_valid_in), .mul_func3(mul_func3), .mul_rs1(mul_rs1),
    .mul_rs2(mul_rs2), .mul_rd_tag(mul_rd_tag), .mul_busy(mul_busy),
    .mul_valid_out(mul_valid_out), .mul_result(mul_result), .mul_rd_tag_out(mul_rd_tag_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .sb_pending(sb_pending), .err_tag(err_tag), .err_unexp(err_unexp)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [4:0]  rs1i, rs2i;
    logic [31:0] v1, v2;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        exp_wb;
    logic [31:0] exp_sb;
  } vec_t;

  vec_t vecs [5];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic present(input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] v1, input logic [31:0] v2, input logic [4:0] rd);
    dec_func3 = f3; dec_rs1_idx = r1; dec_rs2_idx = r2;
    dec_rs1_val = v1; dec_rs2_val = v2; dec_rd = rd;
  endtask

  // Accept edge happens inside; returns with the DUT in ISSUE.
  task automatic issue(input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] v1, input logic [31:0] v2, input logic [4:0] rd);
    present(f3, r1, r2, v1, v2, rd);
    dec_valid = 1'b1;
    cyc();
    dec_valid = 1'b0;
  endtask

  // Called with the DUT in WAIT; pulses the multiplier result for one cycle.
  task automatic ret(input logic [31:0] res, input logic [4:0] tag);
    mul_valid_out = 1'b1; mul_result = res; mul_rd_tag_out = tag;
    cyc();
    mul_valid_out = 1'b0;
  endtask

  task automatic handshake();
    wb_ready = 1'b1;
    cyc();
    wb_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    present(v.f3, v.rs1i, v.rs2i, v.v1, v.v2, v.rd);
    #1;
    chk($sformatf("v%0d dec_ready", i), 64'(dec_ready), 64'd1);
    issue(v.f3, v.rs1i, v.rs2i, v.v1, v.v2, v.rd);
    chk($sformatf("v%0d mul_valid_in", i), 64'(mul_valid_in), 64'd1);
    chk($sformatf("v%0d mul_func3", i), 64'(mul_func3), 64'(v.f3));
    chk($sformatf("v%0d mul_rs1", i), 64'(mul_rs1), 64'(v.v1));
    chk($sformatf("v%0d mul_rs2", i), 64'(mul_rs2), 64'(v.v2));
    chk($sformatf("v%0d mul_rd_tag", i), 64'(mul_rd_tag), 64'(v.rd));
    chk($sformatf("v%0d sb_set", i), 64'(sb_pending), 64'(v.exp_sb));
    chk($sformatf("v%0d dec_ready_issue", i), 64'(dec_ready), 64'd0);
    cyc();
    chk($sformatf("v%0d pulse_1cyc", i), 64'(mul_valid_in), 64'd0);
    ret(v.res, v.rd);
    chk($sformatf("v%0d wb_valid", i), 64'(wb_valid), 64'(v.exp_wb));
    if (v.exp_wb) begin
      chk($sformatf("v%0d wb_rd", i), 64'(wb_rd), 64'(v.rd));
      chk($sformatf("v%0d wb_data", i), 64'(wb_data), 64'(v.res));
      chk($sformatf("v%0d sb_held", i), 64'(sb_pending), 64'(v.exp_sb));
    end
    handshake();
    chk($sformatf("v%0d wb_done", i), 64'(wb_valid), 64'd0);
    chk($sformatf("v%0d sb_clear", i), 64'(sb_pending), 64'd0);
  endtask

  initial begin
    vecs[0] = '{3'b000, 5'd6, 5'd7, 32'd6, 32'd7, 5'd5, 32'd42, 1'b1, 32'h0000_0020};
    vecs[1] = '{3'b001, 5'd1, 5'd2, 32'h8000_0000, 32'd2, 5'd10, 32'hFFFF_FFFF, 1'b1, 32'h0000_0400};
    vecs[2] = '{3'b011, 5'd3, 5'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFE, 1'b1, 32'h8000_0000};
    vecs[3] = '{3'b010, 5'd8, 5'd9, 32'hFFFF_FFFF, 32'd2, 5'd12, 32'hFFFF_FFFF, 1'b1, 32'h0000_1000};
    vecs[4] = '{3'b000, 5'd11, 5'd13, 32'd3, 32'd41, 5'd0, 32'd123, 1'b0, 32'h0000_0000};

    rst = 1'b1; dec_valid = 1'b0; mul_busy = 1'b0; mul_valid_out = 1'b0;
    mul_result = '0; mul_rd_tag_out = '0; wb_ready = 1'b0;
    present(3'd0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    cyc(); cyc();
    chk("rst dec_ready", 64'(dec_ready), 64'd0);
    rst = 1'b0;
    cyc();
    chk("rst mul_valid_in", 64'(mul_valid_in), 64'd0);
    chk("rst wb_valid", 64'(wb_valid), 64'd0);
    chk("rst sb_pending", 64'(sb_pending), 64'd0);
    chk("rst err_tag", 64'(err_tag), 64'd0);
    chk("rst err_unexp", 64'(err_unexp), 64'd0);
    chk("rst mul_rs1", 64'(mul_rs1), 64'd0);
    chk("rst mul_rd_tag", 64'(mul_rd_tag), 64'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Multiplier busy blocks issue.
    mul_busy = 1'b1; present(3'd0, 5'd1, 5'd2, 32'd1, 32'd1, 5'd3); #1;
    chk("busy dec_ready", 64'(dec_ready), 64'd0);
    mul_busy = 1'b0; #1;
    chk("unbusy dec_ready", 64'(dec_ready), 64'd1);

    // RAW: B reads x3 while A's write to x3 sits in the FIFO.
    issue(3'd0, 5'd0, 5'd0, 32'd5, 32'd5, 5'd3);
    cyc();
    ret(32'd25, 5'd3);
    present(3'd0, 5'd3, 5'd0, 32'd25, 32'd0, 5'd8); #1;
    chk("raw stall", 64'(dec_ready), 64'd0);
    wb_ready = 1'b1; #1;
    chk("raw hs cycle", 64'(dec_ready), 64'd0);
    cyc(); wb_ready = 1'b0; #1;
    chk("raw released", 64'(dec_ready), 64'd1);
    issue(3'd0, 5'd3, 5'd0, 32'd25, 32'd0, 5'd8);
    chk("raw B issue", 64'(mul_valid_in), 64'd1);
    chk("raw B tag", 64'(mul_rd_tag), 64'd8);
    cyc();
    ret(32'd0, 5'd8);
    handshake();

    // WAW: rd pending blocks a second write to the same register.
    issue(3'd0, 5'd0, 5'd0, 32'd1, 32'd1, 5'd20);
    cyc();
    ret(32'd1, 5'd20);
    present(3'd0, 5'd0, 5'd0, 32'd2, 32'd2, 5'd20); #1;
    chk("waw stall", 64'(dec_ready), 64'd0);
    handshake();

    // FIFO full with wb_ready held low.
    issue(3'd0, 5'd0, 5'd0, 32'd1, 32'd11, 5'd1);
    cyc();
    ret(32'd11, 5'd1);
    issue(3'd0, 5'd0, 5'd0, 32'd2, 32'd11, 5'd2);
    cyc();
    ret(32'd22, 5'd2);
    present(3'd0, 5'd0, 5'd0, 32'd3, 32'd3, 5'd3); #1;
    chk("full sb", 64'(sb_pending), 64'h6);
    chk("full dec_ready", 64'(dec_ready), 64'd0);
    chk("full head rd", 64'(wb_rd), 64'd1);
    chk("full head data", 64'(wb_data), 64'd11);
    wb_ready = 1'b1;
    cyc();
    chk("full 2nd rd", 64'(wb_rd), 64'd2);
    chk("full 2nd data", 64'(wb_data), 64'd22);
    chk("full dec_ready rises", 64'(dec_ready), 64'd1);
    cyc();
    wb_ready = 1'b0;
    chk("full drained", 64'(wb_valid), 64'd0);
    chk("full sb clear", 64'(sb_pending), 64'd0);

    // Unexpected result in IDLE.
    mul_valid_out = 1'b1; mul_result = 32'd77; mul_rd_tag_out = 5'd7;
    cyc();
    mul_valid_out = 1'b0;
    chk("unexp set", 64'(err_unexp), 64'd1);
    chk("unexp no push", 64'(wb_valid), 64'd0);
    chk("err_tag still 0", 64'(err_tag), 64'd0);
    cyc();
    chk("unexp sticky", 64'(err_unexp), 64'd1);

    // Wrong tag; writeback still uses the stored rd.
    issue(3'd0, 5'd0, 5'd0, 32'd5, 32'd11, 5'd4);
    cyc();
    ret(32'd55, 5'd9);
    chk("tag err", 64'(err_tag), 64'd1);
    chk("tag wb_rd", 64'(wb_rd), 64'd4);
    chk("tag wb_data", 64'(wb_data), 64'd55);
    handshake();
    chk("tag sticky", 64'(err_tag), 64'd1);

    // Asynchronous reset while waiting on the multiplier.
    issue(3'd1, 5'd0, 5'd0, 32'd9, 32'd9, 5'd6);
    cyc();
    chk("pre-rst sb", 64'(sb_pending), 64'h40);
    rst = 1'b1; #1;
    chk("arst sb", 64'(sb_pending), 64'd0);
    chk("arst errs", 64'({err_tag, err_unexp}), 64'd0);
    chk("arst mul", 64'({mul_valid_in, mul_func3, mul_rd_tag}), 64'd0);
    chk("arst rs", 64'({mul_rs1, mul_rs2}), 64'd0);
    chk("arst wb_valid", 64'(wb_valid), 64'd0);
    chk("arst dec_ready", 64'(dec_ready), 64'd0);
    cyc();
    rst = 1'b0;
    cyc();
    run_vec(vecs[0], 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_dispatch.md
Name: mul_dispatch

Overview:
- Issue and writeback controller on the requester side of the M-extension multiplier handshake (valid_in/func3/rs1/rs2/rd_tag_in, then busy, then valid_out/result_out/rd_tag_out).
- Accepts decoded multiply ops from decode, performs scoreboard hazard checks, and issues one op at a time to the multiplier.
- Captures the returned result and writes it back to the register file through a small result FIFO.
- Keeps a 32-bit pending-destination scoreboard for the rest of the pipeline.

Parameters:
- WIDTH, 32, operand/result width.
- FIFO_DEPTH, 2, result FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- dec_valid  input  1  decoded M-op offered.
- dec_ready  output  1  op accepted this cycle when dec_valid is also high.
- dec_func3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- dec_rs1_idx, dec_rs2_idx  input  5 each  source register indices, used for hazard check.
- dec_rs1_val, dec_rs2_val  input  WIDTH each  source operand values.
- dec_rd  input  5  destination register.
- mul_valid_in  output  1  one-cycle issue pulse to the multiplier.
- mul_func3  output  3  to multiplier.
- mul_rs1, mul_rs2  output  WIDTH each  to multiplier.
- mul_rd_tag  output  5  to multiplier.
- mul_busy  input  1  multiplier busy.
- mul_valid_out  input  1  multiplier result valid.
- mul_result  input  WIDTH  multiplier result.
- mul_rd_tag_out  input  5  multiplier result tag.
- wb_valid  output  1  writeback request.
- wb_ready  input  1  register file write port granted.
- wb_rd  output  5  writeback register index.
- wb_data  output  WIDTH  writeback data.
- sb_pending  output  32  bit i set means register i has an in-flight write; bit 0 is always 0.
- err_tag  output  1  sticky; returned tag did not match the issued rd.
- err_unexp  output  1  sticky; mul_valid_out arrived while no op was outstanding.

Behaviour:
- Reset: state IDLE. dec_ready, mul_valid_in, wb_valid, sb_pending, err_tag and err_unexp are all 0. FIFO is empty. mul_func3, mul_rs1, mul_rs2 and mul_rd_tag are 0. Reset mid-operation abandons any in-flight op; the multiplier shares rst.
- States:
  - IDLE: no op outstanding.
  - ISSUE: mul_valid_in is 1 for exactly this one cycle.
  - WAIT: awaiting mul_valid_out.
- dec_ready is combinational and is 1 only when all of the following hold:
  - state is IDLE;
  - mul_busy is 0;
  - FIFO count is below FIFO_DEPTH;
  - no RAW hazard: for each nonzero rs index, the matching sb_pending bit is 0;
  - no WAW hazard: if dec_rd is nonzero, sb_pending[dec_rd] is 0.
- Accept, at the edge where dec_valid and dec_ready are both 1:
  - func3, operands and rd are registered onto the mul_* outputs;
  - the stored rd is captured;
  - sb_pending[dec_rd] is set, unless dec_rd is 0;
  - state moves to ISSUE. mul_valid_in is high the following cycle, then state moves to WAIT.
- mul_* outputs hold their values until the next accept.
- WAIT: on mul_valid_out:
  - if the stored rd is nonzero, push {stored rd, mul_result} into the FIFO;
  - if the stored rd is 0, drop the result and write nothing back;
  - state returns to IDLE.
- Tag mismatch: if mul_rd_tag_out differs from the stored rd, set err_tag. Writeback still uses the stored rd.
- mul_valid_out in IDLE or ISSUE: ignored, and err_unexp is set.
- Writeback:
  - wb_valid = FIFO not empty; wb_rd and wb_data come from the FIFO head.
  - Pop happens when wb_valid and wb_ready are both 1.
  - The same edge clears sb_pending[wb_rd].
- Scoreboard timing: a bit clears on the writeback handshake, not when the result arrives. There is no same-cycle bypass: a dependent op stalls during the handshake cycle and may be accepted the cycle after.
- Simultaneous set and clear of the same bit cannot occur, because the WAW check blocks a set while the bit is pending. Sets and clears of different bits in the same cycle both take effect.
- FIFO behaviour:
  - A push always has room, because accept requires count below FIFO_DEPTH and only one op is ever outstanding.
  - A simultaneous push and pop keeps count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: dec accept to mul_valid_in is 1 cycle. mul_valid_out to wb_valid is 1 cycle if the FIFO was empty.
- Throughput: at most one op in flight; a new accept needs mul_busy low and state IDLE.

Test Plan:
- Reset, then accept MUL rd=5, rs1=6, rs2=7 -> at the next cycle mul_valid_in=1 for one cycle with mul_rs1=6, mul_rs2=7, mul_rd_tag=5, and sb_pending[5]=1. When mul_valid_out returns 42 with tag 5, wb_valid=1, wb_rd=5, wb_data=42; after the handshake sb_pending[5]=0.
- RAW: op A rd=3 is pending and op B has rs1_idx=3 -> dec_ready=0 until the cycle after A's writeback handshake, then B is accepted.
- rd=0 op -> issues normally; sb_pending stays 0; no wb_valid after the result returns.
- Hold wb_ready=0 across two completed ops (rd=1 then rd=2) -> FIFO full, and a third op is stalled with dec_ready=0. Release wb_ready -> writebacks come out in order 1 then 2, then dec_ready rises.
- Inject mul_valid_out in IDLE -> err_unexp=1 and stays set; no FIFO push. Return a wrong tag (9 for rd=4) -> err_tag=1 and writeback still goes to rd=4.
- Assert rst during WAIT -> all outputs return to reset values immediately; the next accept proceeds normally.
